uart_baud_gen: RTL and testbench

- Parametrised successor to the fixed half-period baud toggler.
- Produces single-cycle strobes instead of a divided clock:
  - an oversample tick;
  - a mid-bit sample tick;
  - a full-bit tick.
- The divisor is runtime-programmable; the phase can be resynchronised by the UART receiver on start-bit detection.
- Sits between the system clock domain and the uart_tx / uart_rx engines. All logic runs in the clk_i domain; no derived clocks.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tick_div.sv | 33 +++
 rtl/uart_baud_gen.sv | 117 +++++++++++
 tb/tb_uart_baud_gen.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and the reset-default divisor calculation for the UART baud generator.
package uart_pkg;
  localparam int OS_RATE_DEF = 16;
  localparam int DIV_W_DEF   = 16;
  localparam int FRAC_W_DEF  = 4;
  localparam int OS_IDX_W    = $clog2(OS_RATE_DEF);

  // Integer clocks per oversample tick, truncated.
  function automatic int calc_div(input int clk, input int baud, input int os);
    return clk / (baud * os);
  endfunction
endpackage

// File: rtl/uart_tick_div.sv
// Clock-cycle counter that flags the last cycle of each oversample period.
// tc_o is combinational and means "the next edge wraps the counter".
module uart_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             carry_i,
  output logic             tc_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   last_cnt;

  // Compare with >= so a divisor shrunk while frozen still wraps cleanly.
  always_comb begin
    last_cnt = '0;
    if (div_i != '0) last_cnt = {1'b0, div_i} - (DIV_W+1)'(1);
    last_cnt = last_cnt + (DIV_W+1)'(carry_i);
    tc_o     = en_i && !clr_i && ({1'b0, cnt_q} >= last_cnt);
    cnt_d    = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (tc_o) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_baud_gen.sv
// Programmable baud strobe generator: oversample, mid-bit and bit-end ticks.
// Define UART_BAUD_FRAC_EN to enable the fractional divisor accumulator.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int OS_RATE   = OS_RATE_DEF,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [DIV_W-1:0]           div_int_i,
  input  logic [FRAC_W-1:0]          div_frac_i,
  input  logic                       div_load_i,
  input  logic                       sync_i,
  output logic                       os_tick_o,
  output logic                       mid_tick_o,
  output logic                       bit_tick_o,
  output logic [$clog2(OS_RATE)-1:0] os_idx_o
);
  localparam int IDX_W = (OS_RATE == OS_RATE_DEF) ? OS_IDX_W : $clog2(OS_RATE);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(calc_div(CLK_RATE, BAUD_RATE, OS_RATE));

  // Strobes are single-cycle pulses registered on the edge that completes the
  // period; consumers sample them as plain enables, there is no back-pressure.
  logic             tc, wrap, xfer, carry;
  logic [DIV_W-1:0] div_act_q, div_act_d, div_shd_q, div_shd_d;
  logic [IDX_W-1:0] os_idx_q, os_idx_d;
  logic             os_tick_q, os_tick_d, mid_tick_q, mid_tick_d, bit_tick_q, bit_tick_d;

  uart_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (en_i),
    .clr_i   (sync_i),
    .div_i   (div_act_q),
    .carry_i (carry),
    .tc_o    (tc)
  );

  // Divisor changes only take effect at a bit boundary, when idle or on resync.
  always_comb begin
    wrap       = tc && (os_idx_q == IDX_W'(OS_RATE - 1));
    xfer       = sync_i || !en_i || wrap;
    div_shd_d  = div_load_i ? div_int_i : div_shd_q;
    div_act_d  = xfer ? div_shd_d : div_act_q;
    os_idx_d   = os_idx_q;
    os_tick_d  = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;
    if (sync_i) begin
      os_idx_d = '0;
    end else if (tc) begin
      os_idx_d   = wrap ? '0 : os_idx_q + IDX_W'(1);
      os_tick_d  = 1'b1;
      mid_tick_d = (os_idx_q == IDX_W'(OS_RATE/2 - 1));
      bit_tick_d = wrap;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_act_q  <= DEF_DIV;
      div_shd_q  <= DEF_DIV;
      os_idx_q   <= '0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      div_act_q  <= div_act_d;
      div_shd_q  <= div_shd_d;
      os_idx_q   <= os_idx_d;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_act_q, frac_shd_q, frac_shd_d, frac_acc_q, frac_acc_d;
  logic [FRAC_W:0]   frac_sum;

  // The carry of the add that ends this period stretches this period by one.
  always_comb begin
    frac_shd_d = div_load_i ? div_frac_i : frac_shd_q;
    frac_sum   = {1'b0, frac_acc_q} + {1'b0, frac_act_q};
    carry      = frac_sum[FRAC_W];
    frac_acc_d = frac_acc_q;
    if (sync_i)  frac_acc_d = '0;
    else if (tc) frac_acc_d = frac_sum[FRAC_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      frac_act_q <= '0;
      frac_shd_q <= '0;
      frac_acc_q <= '0;
    end else begin
      frac_shd_q <= frac_shd_d;
      frac_act_q <= xfer ? frac_shd_d : frac_act_q;
      frac_acc_q <= frac_acc_d;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac_i;
  assign carry       = 1'b0;
`endif

  assign os_tick_o  = os_tick_q;
  assign mid_tick_o = mid_tick_q;
  assign bit_tick_o = bit_tick_q;
  assign os_idx_o   = os_idx_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: strobe spacing measured in clock edges.
module tb_uart_baud_gen;
  localparam int SEL_OS  = 0;
  localparam int SEL_MID = 1;
  localparam int SEL_BIT = 2;
  localparam int LIMIT   = 20000;

  logic        clk = 1'b0;
  logic        rst_n, en, div_load, sync;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick, mid_tick, bit_tick;
  logic [3:0]  os_idx;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n;
  int          exp_frac;

  uart_baud_gen dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .div_int_i  (div_int),
    .div_frac_i (div_frac),
    .div_load_i (div_load),
    .sync_i     (sync),
    .os_tick_o  (os_tick),
    .mid_tick_o (mid_tick),
    .bit_tick_o (bit_tick),
    .os_idx_o   (os_idx)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cycle(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Counts negedges until the selected strobe is seen; returns LIMIT on timeout.
  task automatic wait_strobe(input int sel, output int cnt);
    logic hit;
    hit = 1'b0;
    cnt = 0;
    while (!hit && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
      case (sel)
        SEL_OS:  hit = os_tick;
        SEL_MID: hit = mid_tick;
        default: hit = bit_tick;
      endcase
    end
  endtask

  task automatic skip_os(input int k);
    int d;
    for (int i = 0; i < k; i++) wait_strobe(SEL_OS, d);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; div_int = '0; div_frac = '0; div_load = 1'b0; sync = 1'b0;
    cycle(3);
    check("rst_os", os_tick, 0);
    check("rst_mid", mid_tick, 0);
    check("rst_bit", bit_tick, 0);
    check("rst_idx", os_idx, 0);

    // default divisor 651
    rst_n = 1'b1;
    wait_strobe(SEL_OS, n);  check("first_os", n, 651);
    wait_strobe(SEL_OS, n);  check("os_period", n, 651);
    wait_strobe(SEL_MID, n); check("mid_after_2os", n, 3906);
    check("mid_idx", os_idx, 8);
    wait_strobe(SEL_BIT, n); check("bit_after_mid", n, 5208);
    check("bit_idx", os_idx, 0);
    wait_strobe(SEL_BIT, n); check("bit_period", n, 10416);

    // runtime load mid-bit waits for the bit boundary
    skip_os(3);
    div_int = 16'd10; div_load = 1'b1; cycle(1); div_load = 1'b0;
    wait_strobe(SEL_OS, n);  check("old_period_kept", n + 1, 651);
    wait_strobe(SEL_BIT, n); check("old_bit_rest", n, 7812);
    wait_strobe(SEL_OS, n);  check("new_os_1", n, 10);
    wait_strobe(SEL_OS, n);  check("new_os_2", n, 10);
    wait_strobe(SEL_BIT, n); check("new_bit_rest", n, 140);

    // load while disabled applies immediately
    en = 1'b0; div_int = 16'd20; div_load = 1'b1; cycle(1); div_load = 1'b0; en = 1'b1;
    wait_strobe(SEL_OS, n);  check("idle_load_os", n, 20);
    cycle(5); en = 1'b0; cycle(5);
    check("frozen_no_os", os_tick, 0);
    en = 1'b1;
    wait_strobe(SEL_OS, n);  check("freeze_shift", n, 15);

    // zero divisor behaves as one
    en = 1'b0; div_int = 16'd0; div_load = 1'b1; sync = 1'b1; cycle(1);
    div_load = 1'b0; sync = 1'b0; en = 1'b1;
    wait_strobe(SEL_BIT, n); check("div0_bit_1", n, 16);
    wait_strobe(SEL_BIT, n); check("div0_bit_2", n, 16);
    wait_strobe(SEL_OS, n);  check("div0_os", n, 1);

    // sync coinciding with a terminal count
    en = 1'b0; div_int = 16'd10; div_load = 1'b1; sync = 1'b1; cycle(1);
    div_load = 1'b0; sync = 1'b0; en = 1'b1;
    skip_os(11);
    check("pre_sync_idx", os_idx, 11);
    cycle(9);
    sync = 1'b1; cycle(1); sync = 1'b0;
    check("sync_no_os", os_tick, 0);
    check("sync_idx", os_idx, 0);
    wait_strobe(SEL_MID, n); check("sync_mid", n, 80);
    wait_strobe(SEL_BIT, n); check("sync_bit", n, 80);

    // fractional divisor 4 + 8/16
`ifdef UART_BAUD_FRAC_EN
    exp_frac = 72;
`else
    exp_frac = 64;
`endif
    en = 1'b0; div_int = 16'd4; div_frac = 4'd8; div_load = 1'b1; sync = 1'b1; cycle(1);
    div_load = 1'b0; sync = 1'b0; en = 1'b1;
    wait_strobe(SEL_BIT, n); check("frac_bit", n, exp_frac);

    // reset mid-bit restores the default divisor
    skip_os(9);
    check("pre_rst_idx", os_idx, 9);
    rst_n = 1'b0; cycle(2);
    check("mid_rst_idx", os_idx, 0);
    check("mid_rst_os", os_tick, 0);
    rst_n = 1'b1;
    wait_strobe(SEL_BIT, n); check("post_rst_bit", n, 10416);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
